// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 message padder.
package md5_pkg;

  // Padder control states.
  typedef enum logic [2:0] {
    StFill,
    StPad80,
    StPadz,
    StLen,
    StEmit
  } state_e;

  localparam logic [7:0] PadByte    = 8'h80;
  localparam logic [6:0] LenOffset  = 7'd56;
  localparam logic [6:0] BlockBytes = 7'd64;

  // Chunk index of each 128-bit slice of a block, in strobe order en1..en4.
  localparam logic [1:0] Chunk1 = 2'd0;
  localparam logic [1:0] Chunk2 = 2'd1;
  localparam logic [1:0] Chunk3 = 2'd2;
  localparam logic [1:0] Chunk4 = 2'd3;

  // First buffer word of a chunk.
  function automatic logic [3:0] chunk_base(input logic [1:0] sel);
    return {sel, 2'b00};
  endfunction

endpackage

// File: rtl/md5_blk_buf.sv
// 16 x 32-bit block buffer: byte-lane writes, length-word writes, bulk clear,
// and a 128-bit chunk read mux with the lowest-numbered word in the MSBs.
module md5_blk_buf
  import md5_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         byte_we,
  input  logic [5:0]   byte_idx,
  input  logic [7:0]   byte_data,
  input  logic         len_we,
  input  logic [31:0]  len_lo,
  input  logic [31:0]  len_hi,
  input  logic [1:0]   chunk_sel,
  output logic [127:0] chunk
);

  logic [31:0] mem_q [16];
  logic [3:0]  base;

  // Buffer storage; clear wins over any write in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
    end else begin
      if (byte_we) begin
        // Little-endian packing: byte i lands in lane i%4 of word i/4.
        mem_q[byte_idx[5:2]][{byte_idx[1:0], 3'b000} +: 8] <= byte_data;
      end
      if (len_we) begin
        mem_q[14] <= len_lo;
        mem_q[15] <= len_hi;
      end
    end
  end

  // Chunk read mux.
  always_comb begin
    base  = chunk_base(chunk_sel);
    chunk = {mem_q[base], mem_q[base + 4'd1], mem_q[base + 4'd2], mem_q[base + 4'd3]};
  end

endmodule

// File: rtl/md5_padder.sv
// MD5 message padder: packs bytes into 512-bit blocks, appends 0x80, zero fill
// and the 64-bit bit length, and hands each block to the core as four chunks.
module md5_padder
  import md5_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   din,
  input  logic         din_valid,
  input  logic         din_last,
  output logic         din_ready,
  input  logic         empty_msg,
  input  logic         core_ready,
  output logic [127:0] data_o,
  output logic         en1,
  output logic         en2,
  output logic         en3,
  output logic         en4,
  output logic         blk_last,
  output logic         done
);

  state_e             state_q, state_d;
  logic [6:0]         byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]   bit_len_q, bit_len_d;
  logic               fin_q, fin_d;
  logic               pend80_q, pend80_d;
  logic               msg_end_q, msg_end_d;   // message ended, padding still owed
  logic               active_q, active_d;     // chunk burst in progress
  logic [1:0]         beat_q, beat_d;
  logic               done_q, done_d;
  logic [127:0]       hold_q, hold_d;         // last chunk driven, held between bursts

  logic               buf_clear;
  logic               buf_byte_we;
  logic [7:0]         buf_byte;
  logic               buf_len_we;
  logic [63:0]        len_ext;
  logic [127:0]       chunk;

  md5_blk_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (buf_clear),
    .byte_we   (buf_byte_we),
    .byte_idx  (byte_cnt_q[5:0]),
    .byte_data (buf_byte),
    .len_we    (buf_len_we),
    .len_lo    (len_ext[31:0]),
    .len_hi    (len_ext[63:32]),
    .chunk_sel (beat_q),
    .chunk     (chunk)
  );

  // Zero-extend the bit length to the 64-bit trailer.
  always_comb begin
    len_ext              = '0;
    len_ext[LEN_W-1:0]   = bit_len_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StFill;
      byte_cnt_q <= '0;
      bit_len_q  <= '0;
      fin_q      <= 1'b0;
      pend80_q   <= 1'b0;
      msg_end_q  <= 1'b0;
      active_q   <= 1'b0;
      beat_q     <= Chunk1;
      done_q     <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_len_q  <= bit_len_d;
      fin_q      <= fin_d;
      pend80_q   <= pend80_d;
      msg_end_q  <= msg_end_d;
      active_q   <= active_d;
      beat_q     <= beat_d;
      done_q     <= done_d;
      hold_q     <= hold_d;
    end
  end

  // Next-state logic and buffer write control.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    bit_len_d   = bit_len_q;
    fin_d       = fin_q;
    pend80_d    = pend80_q;
    msg_end_d   = msg_end_q;
    active_d    = active_q;
    beat_d      = beat_q;
    done_d      = 1'b0;
    hold_d      = hold_q;
    buf_clear   = 1'b0;
    buf_byte_we = 1'b0;
    buf_byte    = '0;
    buf_len_we  = 1'b0;

    unique case (state_q)
      StFill: begin
        if (din_valid) begin
          buf_byte_we = 1'b1;
          buf_byte    = din;
          byte_cnt_d  = byte_cnt_q + 7'd1;
          bit_len_d   = bit_len_q + LEN_W'(8);
          if (din_last) begin
            // A last byte that also fills the block is handled by PAD80.
            state_d   = StPad80;
            msg_end_d = 1'b1;
          end else if (byte_cnt_q == BlockBytes - 7'd1) begin
            state_d = StEmit;
            fin_d   = 1'b0;
          end
        end else if (empty_msg && byte_cnt_q == '0) begin
          state_d   = StPad80;
          msg_end_d = 1'b1;
        end
      end

      StPad80: begin
        if (byte_cnt_q == BlockBytes) begin
          // No room left: the 0x80 opens the next block.
          state_d  = StEmit;
          fin_d    = 1'b0;
          pend80_d = 1'b1;
        end else begin
          buf_byte_we = 1'b1;
          buf_byte    = PadByte;
          byte_cnt_d  = byte_cnt_q + 7'd1;
          state_d     = StPadz;
        end
      end

      StPadz: begin
        if (byte_cnt_q == LenOffset) begin
          state_d = StLen;
        end else if (byte_cnt_q == BlockBytes) begin
          // Length does not fit: it goes into a following all-pad block.
          state_d = StEmit;
          fin_d   = 1'b0;
        end else begin
          buf_byte_we = 1'b1;
          buf_byte    = 8'h00;
          byte_cnt_d  = byte_cnt_q + 7'd1;
        end
      end

      StLen: begin
        buf_len_we = 1'b1;
        fin_d      = 1'b1;
        state_d    = StEmit;
      end

      StEmit: begin
        if (!active_q) begin
          // core_ready is only looked at before the burst starts.
          if (core_ready) begin
            active_d = 1'b1;
            beat_d   = Chunk1;
          end
        end else begin
          hold_d = chunk;
          beat_d = beat_q + 2'd1;
          if (beat_q == Chunk4) begin
            active_d   = 1'b0;
            buf_clear  = 1'b1;
            byte_cnt_d = '0;
            if (fin_q) begin
              done_d    = 1'b1;
              bit_len_d = '0;
              fin_d     = 1'b0;
              msg_end_d = 1'b0;
              state_d   = StFill;
            end else if (pend80_q) begin
              pend80_d = 1'b0;
              state_d  = StPad80;
            end else if (msg_end_q) begin
              state_d = StPadz;
            end else begin
              state_d = StFill;
            end
          end
        end
      end

      default: state_d = StFill;
    endcase
  end

  // Output decode; ready is forced low while reset is held.
  always_comb begin
    din_ready = (state_q == StFill) && reset;
    en1       = active_q && (beat_q == Chunk1);
    en2       = active_q && (beat_q == Chunk2);
    en3       = active_q && (beat_q == Chunk3);
    en4       = active_q && (beat_q == Chunk4);
    blk_last  = active_q && fin_q;
    data_o    = active_q ? chunk : hold_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_md5_padder.sv
// Self-checking bench for md5_padder: a byte-level padding model feeds an
// expected-chunk queue that a per-cycle compare process checks against.
module tb_md5_padder;

  logic         clk;
  logic         reset;
  logic [7:0]   din;
  logic         din_valid;
  logic         din_last;
  logic         din_ready;
  logic         empty_msg;
  logic         core_ready;
  logic [127:0] data_o;
  logic         en1, en2, en3, en4;
  logic         blk_last;
  logic         done;

  md5_padder #(.LEN_W(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_ready  (din_ready),
    .empty_msg  (empty_msg),
    .core_ready (core_ready),
    .data_o     (data_o),
    .en1        (en1),
    .en2        (en2),
    .en3        (en3),
    .en4        (en4),
    .blk_last   (blk_last),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           chunk;
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] en1_log[$];
  logic [127:0] en4_log[$];
  logic [7:0]   msg_buf [0:127];
  int           n_checks;
  int           n_fail;
  int           n_en;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pad a message of n bytes from msg_buf and queue the expected chunks.
  task automatic model_push(input int n);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [127:0] d;
    logic [31:0]  w;
    int           nblk, o;
    for (int i = 0; i < n; i++) p.push_back(msg_buf[i]);
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(n) * 64'd8;
    for (int k = 0; k < 8; k++) p.push_back(bits[8*k +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int c = 0; c < 4; c++) begin
        d = '0;
        for (int j = 4 * c; j < 4 * c + 4; j++) begin
          o = b * 64 + 4 * j;
          w = {p[o+3], p[o+2], p[o+1], p[o]};
          d = {d[95:0], w};
        end
        exp_q.push_back('{chunk: c, data: d, last: (b == nblk - 1)});
      end
    end
  endtask

  // Per-cycle compare against the model queue.
  initial begin : compare
    logic [3:0]   en_vec;
    logic [127:0] held;
    logic         prev_last4;
    exp_t         e;
    held       = '0;
    prev_last4 = 1'b0;
    forever begin
      @(negedge clk);
      en_vec = {en4, en3, en2, en1};
      if (!reset) begin
        exp_q.delete();
        held       = '0;
        prev_last4 = 1'b0;
        check("rst_strobes", 128'(en_vec), 128'd0);
        check("rst_data", data_o, 128'd0);
        check("rst_flags", 128'({blk_last, done, din_ready}), 128'd0);
      end else begin
        check("done", 128'(done), 128'(prev_last4));
        if (en_vec != 4'b0) begin
          n_en++;
          check("onehot", 128'($countones(en_vec)), 128'd1);
          if (exp_q.size() == 0) begin
            check("spurious_strobe", 128'(en_vec), 128'd0);
          end else begin
            e = exp_q.pop_front();
            check("chunk_sel", 128'(en_vec), 128'(4'b0001 << e.chunk));
            check("data", data_o, e.data);
            check("blk_last", 128'(blk_last), 128'(e.last));
          end
          held = data_o;
          if (en1) en1_log.push_back(data_o);
          if (en4) en4_log.push_back(data_o);
          prev_last4 = en4 & blk_last;
        end else begin
          check("data_hold", data_o, held);
          check("blk_last_idle", 128'(blk_last), 128'd0);
          prev_last4 = 1'b0;
        end
      end
    end
  end

  // Feed n bytes from msg_buf; optionally keep a junk byte valid afterwards.
  task automatic feed(input int n, input bit hold_junk);
    int guard;
    bit acc;
    model_push(n);
    for (int i = 0; i < n; i++) begin
      din       = msg_buf[i];
      din_valid = 1'b1;
      din_last  = (i == n - 1);
      acc       = 1'b0;
      guard     = 0;
      while (!acc) begin
        @(negedge clk);
        acc = din_ready;
        @(posedge clk);
        #1;
        guard++;
        if (guard > 200) begin
          check("feed_timeout", 128'd1, 128'd0);
          din_valid = 1'b0;
          din_last  = 1'b0;
          return;
        end
      end
    end
    din_last = 1'b0;
    if (hold_junk) begin
      din       = 8'hFF;
      din_valid = 1'b1;
    end else begin
      din_valid = 1'b0;
    end
  endtask

  // Wait for done, then confirm every expected chunk was seen.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen      = 1'b1;
        din_valid = 1'b0;
      end
    end
    check("done_seen", 128'(seen), 128'd1);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    en1_log.delete();
    en4_log.delete();
  endtask

  task automatic load_zeros(input int n);
    for (int i = 0; i < n; i++) msg_buf[i] = 8'h00;
  endtask

  task automatic run_abc();
    clear_logs();
    msg_buf[0] = 8'h61;
    msg_buf[1] = 8'h62;
    msg_buf[2] = 8'h63;
    feed(3, 1'b0);
    wait_done();
    check("abc_blocks", 128'(en4_log.size()), 128'd1);
    if (en1_log.size() == 1)
      check("abc_en1", en1_log[0], 128'h80636261_00000000_00000000_00000000);
    if (en4_log.size() == 1)
      check("abc_en4", en4_log[0], 128'h00000000_00000000_00000018_00000000);
  endtask

  initial begin : main
    int nen0;
    n_checks   = 0;
    n_fail     = 0;
    n_en       = 0;
    din        = '0;
    din_valid  = 1'b0;
    din_last   = 1'b0;
    empty_msg  = 1'b0;
    core_ready = 1'b1;
    reset      = 1'b1;
    #2 reset   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_din_ready", 128'(din_ready), 128'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("fill_din_ready", 128'(din_ready), 128'd1);
    @(posedge clk);
    #1;

    // Empty message.
    clear_logs();
    model_push(0);
    empty_msg = 1'b1;
    @(posedge clk);
    #1 empty_msg = 1'b0;
    wait_done();
    check("empty_blocks", 128'(en4_log.size()), 128'd1);
    if (en1_log.size() == 1)
      check("empty_en1", en1_log[0], 128'h00000080_00000000_00000000_00000000);
    if (en4_log.size() == 1) check("empty_en4", en4_log[0], 128'd0);

    // "abc".
    run_abc();

    // 55 zero bytes: fits in one block.
    clear_logs();
    load_zeros(55);
    feed(55, 1'b0);
    wait_done();
    check("b55_blocks", 128'(en4_log.size()), 128'd1);
    if (en4_log.size() == 1)
      check("b55_en4", en4_log[0], 128'h00000000_80000000_000001B8_00000000);

    // 56 zero bytes, producer keeps din_valid high while the padder is busy.
    clear_logs();
    load_zeros(56);
    feed(56, 1'b1);
    wait_done();
    check("b56_blocks", 128'(en4_log.size()), 128'd2);
    if (en4_log.size() == 2) begin
      check("b56_blk1_en4", en4_log[0], 128'h00000000_00000000_00000080_00000000);
      check("b56_blk2_en4", en4_log[1], 128'h00000000_00000000_000001C0_00000000);
    end

    // 64 zero bytes with the core held busy.
    clear_logs();
    load_zeros(64);
    core_ready = 1'b0;
    feed(64, 1'b0);
    nen0 = n_en;
    repeat (20) @(posedge clk);
    check("stall_no_strobe", 128'(n_en), 128'(nen0));
    #1 core_ready = 1'b1;
    wait_done();
    check("b64_blocks", 128'(en4_log.size()), 128'd2);
    if (en1_log.size() == 2)
      check("b64_blk2_en1", en1_log[1], 128'h00000080_00000000_00000000_00000000);
    if (en4_log.size() == 2)
      check("b64_blk2_en4", en4_log[1], 128'h00000000_00000000_00000200_00000000);

    // Reset while zero-filling, then a clean "abc".
    clear_logs();
    for (int i = 0; i < 10; i++) msg_buf[i] = 8'(8'h30 + i);
    feed(10, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("midrst_strobes", 128'({en4, en3, en2, en1}), 128'd0);
    check("midrst_data", data_o, 128'd0);
    check("midrst_flags", 128'({blk_last, done, din_ready}), 128'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    nen0 = n_en;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_strobe", 128'(n_en), 128'(nen0));
    run_abc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
